wb_protocol_monitor: RTL and testbench

Synthesizable, parametrised Wishbone classic-cycle protocol monitor bound alongside any Wishbone slave (first user: `uart_top`). It watches master and slave signals without driving the bus. It reports protocol violations as per-cycle pulses and sticky flags. It also keeps read/write transfer counters and the worst-case termination latency, so protocol rules hold in simulation, emulation and silicon debug, not only in formal.

---
 rtl/wb_protocol_monitor.sv | 140 ++++++++++++++
 tb/tb_wb_protocol_monitor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/wb_protocol_monitor.sv
// rtl/wb_protocol_monitor.sv - passive Wishbone classic-cycle protocol monitor
// Flags bus rule violations and tracks transfer counts and worst termination latency.
module wb_protocol_monitor #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16,
    parameter int RETRY_EN    = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_we_i,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    input  logic              viol_clr_i,
    output logic [5:0]        viol_o,
    output logic [5:0]        viol_sticky_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  wait_max_o
);

    // Request age saturates one past the timeout so the timeout compare matches only once.
    localparam int AGE_W = $clog2(ACK_TIMEOUT + 2);
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(ACK_TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_TMO = AGE_W'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CYC,
        ST_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] adr_snap_q;
    logic [DATA_W-1:0] dat_snap_q;
    logic [SEL_W-1:0]  sel_snap_q;
    logic              we_snap_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]  wait_cur;
    logic [AGE_W-1:0]  age_q;
    logic [AGE_W-1:0]  age_cur;
    logic [5:0]        viol_q, sticky_q, viol_d;
    logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q, wait_max_q;

    logic err_v, rty_v, req, term, in_wait, start, changed;

    assign err_v   = (RETRY_EN != 0) & wb_err_i;
    assign rty_v   = (RETRY_EN != 0) & wb_rty_i;
    assign req     = wb_cyc_i & wb_stb_i;
    assign term    = wb_ack_i | err_v | rty_v;
    assign in_wait = (state_q == ST_WAIT);
    assign start   = req & ~in_wait;

    assign changed = (wb_adr_i != adr_snap_q) | (wb_sel_i != sel_snap_q) |
                     (wb_we_i != we_snap_q) | (we_snap_q & (wb_dat_i != dat_snap_q));

    // Latency and age of the current request, counting this cycle.
    assign wait_cur = start ? CNT_W'(1) :
                      ((wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + CNT_W'(1));
    assign age_cur  = start ? AGE_W'(1) :
                      ((age_q == AGE_SAT) ? age_q : age_q + AGE_W'(1));

    always_comb begin
        viol_d    = 6'b0;
        viol_d[0] = wb_stb_i & ~wb_cyc_i;
        viol_d[1] = in_wait & ~req;
        viol_d[2] = in_wait & req & changed;
        viol_d[3] = (wb_ack_i & err_v) | (wb_ack_i & rty_v) | (err_v & rty_v);
        viol_d[4] = term & ~req;
        viol_d[5] = req & ~term & (age_cur == AGE_TMO);
    end

    always_comb begin
        state_d = ST_IDLE;
        if (req && !term) begin
            state_d = ST_WAIT;
        end else if (wb_cyc_i) begin
            state_d = ST_CYC;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            adr_snap_q <= '0;
            dat_snap_q <= '0;
            sel_snap_q <= '0;
            we_snap_q  <= 1'b0;
            wait_cnt_q <= '0;
            age_q      <= '0;
            viol_q     <= '0;
            sticky_q   <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            wait_max_q <= '0;
        end else begin
            state_q  <= state_d;
            viol_q   <= viol_d;
            sticky_q <= (sticky_q & ~{6{viol_clr_i}}) | viol_d;
            if (start) begin
                adr_snap_q <= wb_adr_i;
                dat_snap_q <= wb_dat_i;
                sel_snap_q <= wb_sel_i;
                we_snap_q  <= wb_we_i;
            end
            if (req) begin
                wait_cnt_q <= wait_cur;
                age_q      <= age_cur;
            end
            if (req && term && (wait_cur > wait_max_q)) begin
                wait_max_q <= wait_cur;
            end
            if (req && wb_ack_i) begin
                if (wb_we_i) begin
                    wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                end else begin
                    rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign viol_o        = viol_q;
    assign viol_sticky_o = sticky_q;
    assign busy_o        = in_wait;
    assign rd_cnt_o      = rd_cnt_q;
    assign wr_cnt_o      = wr_cnt_q;
    assign wait_max_o    = wait_max_q;

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// tb/tb_wb_protocol_monitor.sv - table-driven scoreboard bench for wb_protocol_monitor
module tb_wb_protocol_monitor;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, ack, err, rty, clr;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [5:0]  viol, sticky, nr_viol, nr_sticky;
    logic        busy, nr_busy;
    logic [15:0] rd_cnt, wr_cnt, wmax, nr_rd, nr_wr, nr_wmax;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_protocol_monitor #(.RETRY_EN(1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .viol_clr_i(clr),
        .viol_o(viol), .viol_sticky_o(sticky), .busy_o(busy),
        .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .wait_max_o(wmax)
    );

    wb_protocol_monitor #(.RETRY_EN(0)) dut_nr (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .viol_clr_i(clr),
        .viol_o(nr_viol), .viol_sticky_o(nr_sticky), .busy_o(nr_busy),
        .rd_cnt_o(nr_rd), .wr_cnt_o(nr_wr), .wait_max_o(nr_wmax)
    );

    typedef struct {
        logic        rst, cyc, stb, we;
        logic [4:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        ack, err, clr;
        logic [5:0]  ev, es;
        logic        eb;
        logic [15:0] erd, ewr, emax;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic r, input logic c, input logic s, input logic w,
                                input logic [4:0] a, input logic [31:0] d, input logic [3:0] sl,
                                input logic k, input logic e, input logic cl,
                                input logic [5:0] ev, input logic [5:0] es, input logic eb,
                                input logic [15:0] erd, input logic [15:0] ewr,
                                input logic [15:0] emax);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.adr = a; v.dat = d; v.sel = sl;
        v.ack = k; v.err = e; v.clr = cl;
        v.ev = ev; v.es = es; v.eb = eb; v.erd = erd; v.ewr = ewr; v.emax = emax;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        rst = v.rst; cyc = v.cyc; stb = v.stb; we = v.we; adr = v.adr; dat = v.dat;
        sel = v.sel; ack = v.ack; err = v.err; rty = 1'b0; clr = v.clr;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("viol_o",        idx, 32'(viol),    32'(e.ev));
        chk("viol_sticky_o", idx, 32'(sticky),  32'(e.es));
        chk("busy_o",        idx, 32'(busy),    32'(e.eb));
        chk("rd_cnt_o",      idx, 32'(rd_cnt),  32'(e.erd));
        chk("wr_cnt_o",      idx, 32'(wr_cnt),  32'(e.ewr));
        chk("wait_max_o",    idx, 32'(wmax),    32'(e.emax));
        chk("noretry_viol",  idx, 32'(nr_viol), 32'(e.ev & 6'b110111));
        chk("noretry_rd",    idx, 32'(nr_rd),   32'(e.erd));
    endtask

    initial begin
        rst = 1'b1; cyc = 0; stb = 0; we = 0; ack = 0; err = 0; rty = 0; clr = 0;
        adr = '0; dat = '0; sel = '0;

        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 6'h00,6'h00,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 6'h00,6'h00,0, 0,0,0));
        // write, ack on third request cycle
        vecs.push_back(mk(0,1,1,1,5'h03,32'hA5,4'h1,0,0,0, 6'h00,6'h00,1, 0,0,0));
        vecs.push_back(mk(0,1,1,1,5'h03,32'hA5,4'h1,0,0,0, 6'h00,6'h00,1, 0,0,0));
        vecs.push_back(mk(0,1,1,1,5'h03,32'hA5,4'h1,1,0,0, 6'h00,6'h00,0, 0,1,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,             6'h00,6'h00,0, 0,1,3));
        // address change in WAIT
        vecs.push_back(mk(0,1,1,1,5'h03,32'hA5,4'h1,0,0,0, 6'h00,6'h00,1, 0,1,3));
        vecs.push_back(mk(0,1,1,1,5'h04,32'hA5,4'h1,0,0,0, 6'h04,6'h04,1, 0,1,3));
        vecs.push_back(mk(0,1,1,1,5'h03,32'hA5,4'h1,1,0,0, 6'h00,6'h04,0, 0,2,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,             6'h00,6'h04,0, 0,2,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,             6'h00,6'h00,0, 0,2,3));
        // stb without cyc plus ack
        vecs.push_back(mk(0,0,1,0,0,0,0,1,0,0,             6'h11,6'h11,0, 0,2,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,             6'h00,6'h00,0, 0,2,3));
        // ack+err together on a read
        vecs.push_back(mk(0,1,1,0,5'h05,0,4'hF,1,1,0,      6'h08,6'h08,0, 1,2,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,             6'h00,6'h00,0, 1,2,3));
        // stb dropped in WAIT, then ack without request
        vecs.push_back(mk(0,1,1,0,5'h07,0,4'hF,0,0,0,      6'h00,6'h00,1, 1,2,3));
        vecs.push_back(mk(0,1,0,0,5'h07,0,4'hF,0,0,0,      6'h02,6'h02,0, 1,2,3));
        vecs.push_back(mk(0,1,0,0,5'h07,0,4'hF,1,0,0,      6'h10,6'h12,0, 1,2,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,             6'h00,6'h00,0, 1,2,3));
        // back-to-back writes with new fields
        vecs.push_back(mk(0,1,1,1,5'h01,32'h11,4'hF,1,0,0, 6'h00,6'h00,0, 1,3,3));
        vecs.push_back(mk(0,1,1,1,5'h02,32'h22,4'h3,0,0,0, 6'h00,6'h00,1, 1,3,3));
        vecs.push_back(mk(0,1,1,1,5'h02,32'h22,4'h3,1,0,0, 6'h00,6'h00,0, 1,4,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,             6'h00,6'h00,0, 1,4,3));
        // read: data bus may move, latency 4 raises the maximum
        vecs.push_back(mk(0,1,1,0,5'h00,32'h0,4'hF,0,0,0,    6'h00,6'h00,1, 1,4,3));
        vecs.push_back(mk(0,1,1,0,5'h00,32'hFFFF,4'hF,0,0,0, 6'h00,6'h00,1, 1,4,3));
        vecs.push_back(mk(0,1,1,0,5'h00,32'hFFFF,4'hF,0,0,0, 6'h00,6'h00,1, 1,4,3));
        vecs.push_back(mk(0,1,1,0,5'h00,32'hFFFF,4'hF,1,0,0, 6'h00,6'h00,0, 2,4,4));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,               6'h00,6'h00,0, 2,4,4));
        // write data change in WAIT
        vecs.push_back(mk(0,1,1,1,5'h06,32'h1,4'hF,0,0,0, 6'h00,6'h00,1, 2,4,4));
        vecs.push_back(mk(0,1,1,1,5'h06,32'h2,4'hF,0,0,0, 6'h04,6'h04,1, 2,4,4));
        vecs.push_back(mk(0,1,1,1,5'h06,32'h1,4'hF,1,0,0, 6'h00,6'h04,0, 2,5,4));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,            6'h00,6'h00,0, 2,5,4));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // timeout: request held 20 cycles, pulse once after request cycle 16
        for (int k = 1; k <= 20; k++) begin
            apply(mk(0,1,1,0,5'h08,0,4'hF,0,0,0,
                     (k == 16) ? 6'h20 : 6'h00, (k >= 16) ? 6'h20 : 6'h00, 1,
                     2,5,4), 100 + k);
        end
        apply(mk(0,1,1,0,5'h08,0,4'hF,1,0,0, 6'h00,6'h20,0, 3,5,21), 121);
        apply(mk(0,0,0,0,0,0,0,0,0,1,        6'h00,6'h00,0, 3,5,21), 122);

        // reset mid-WAIT: everything clears, held request restarts at latency 1
        apply(mk(0,0,1,0,0,0,0,0,0,0,        6'h01,6'h01,0, 3,5,21), 200);
        apply(mk(0,1,1,0,5'h09,0,4'hF,0,0,0, 6'h00,6'h01,1, 3,5,21), 201);
        apply(mk(1,1,1,0,5'h09,0,4'hF,0,0,0, 6'h00,6'h00,0, 0,0,0),  202);
        apply(mk(0,1,1,0,5'h09,0,4'hF,0,0,0, 6'h00,6'h00,1, 0,0,0),  203);
        apply(mk(0,1,1,0,5'h09,0,4'hF,1,0,0, 6'h00,6'h00,0, 1,0,2),  204);
        apply(mk(0,0,0,0,0,0,0,0,0,0,        6'h00,6'h00,0, 1,0,2),  205);

        chk("scoreboard_empty", 999, 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
